// File: rtl/vp_tile_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vp_pkg: shared types and sizing for the VP encoder tile scheduler.
//   W_C_LENGTH : max compressed weight entries per tile
//   W_LEN_W    : width of a compressed tile length / group count
//   TILE_W     : width of tile count and tile index
//   TIMEOUT    : max RUN cycles without encoder finish before abort
//   sched_state_t : scheduler FSM states
// -----------------------------------------------------------------------------
package vp_pkg;

  localparam int W_C_LENGTH = 474;
  localparam int W_LEN_W    = $clog2(W_C_LENGTH) + 1;
  localparam int TILE_W     = 8;
  localparam int TIMEOUT    = 255;
  localparam int RUN_CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    START,
    RUN,
    DRAIN,
    NEXT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/vp_tile_scheduler_if.sv
// -----------------------------------------------------------------------------
// vp_tile_scheduler_if: groups the scheduler's layer-controller, weight-loader,
// encoder and PE-lane signals.
//   master modport : scheduler side (drives o_*, samples i_*)
//   slave modport  : environment side (drives i_*, samples o_*)
// -----------------------------------------------------------------------------
interface vp_tile_scheduler_if;
  import vp_pkg::*;

  // layer controller
  logic               i_go;
  logic [TILE_W-1:0]  i_num_tiles;
  // weight loader
  logic               o_tile_req;
  logic               i_tile_valid;
  logic [W_LEN_W-1:0] i_tile_wlen;
  // encoder
  logic               o_enc_start;
  logic [W_LEN_W-1:0] o_enc_wlen;
  logic               i_enc_left_ready;
  logic               i_enc_right_ready;
  logic               i_enc_finish;
  // PE lanes
  logic               o_left_issue;
  logic               o_right_issue;
  logic               i_pe_left_busy;
  logic               i_pe_right_busy;
  // status
  logic [TILE_W-1:0]  o_tile_idx;
  logic [W_LEN_W-1:0] o_group_cnt;
  logic               o_busy;
  logic               o_done;
  logic               o_err;

  modport master (
    input  i_go, i_num_tiles, i_tile_valid, i_tile_wlen,
           i_enc_left_ready, i_enc_right_ready, i_enc_finish,
           i_pe_left_busy, i_pe_right_busy,
    output o_tile_req, o_enc_start, o_enc_wlen, o_left_issue, o_right_issue,
           o_tile_idx, o_group_cnt, o_busy, o_done, o_err
  );

  modport slave (
    output i_go, i_num_tiles, i_tile_valid, i_tile_wlen,
           i_enc_left_ready, i_enc_right_ready, i_enc_finish,
           i_pe_left_busy, i_pe_right_busy,
    input  o_tile_req, o_enc_start, o_enc_wlen, o_left_issue, o_right_issue,
           o_tile_idx, o_group_cnt, o_busy, o_done, o_err
  );

endinterface

// File: rtl/vp_sched_perf_cnt.sv
// -----------------------------------------------------------------------------
// vp_sched_perf_cnt: pair of 32-bit saturating event counters.
// Only built when VP_SCHED_PERF_EN is defined.
//   clk, rst_n     : clock, synchronous active-low reset
//   clr            : synchronous clear of both counters
//   inc_a, inc_b   : per-cycle increment enables
//   cnt_a, cnt_b   : counter values, stick at all-ones
// -----------------------------------------------------------------------------
`ifdef VP_SCHED_PERF_EN
module vp_sched_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc_a,
  input  logic        inc_b,
  output logic [31:0] cnt_a,
  output logic [31:0] cnt_b
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (inc_a && (cnt_a != '1)) cnt_a <= cnt_a + 32'd1;
      if (inc_b && (cnt_b != '1)) cnt_b <= cnt_b + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/vp_tile_scheduler.sv
// -----------------------------------------------------------------------------
// vp_tile_scheduler: layer-level sequencer for the VP encoder. Walks a layer
// tile by tile: requests the weight tile, starts the encoder, forwards
// left/right group-ready pulses to the PE lanes, waits for encoder finish and
// PE drain, then advances to the next tile.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus            : vp_tile_scheduler_if.master (all handshake/status signals)
//   o_perf_busy    : cycles with o_busy        (VP_SCHED_PERF_EN only)
//   o_perf_stall   : cycles in REQ or DRAIN    (VP_SCHED_PERF_EN only)
// Optional feature macro: VP_SCHED_PERF_EN.
// -----------------------------------------------------------------------------
module vp_tile_scheduler
  import vp_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  vp_tile_scheduler_if.master bus
`ifdef VP_SCHED_PERF_EN
  ,
  output logic [31:0]         o_perf_busy,
  output logic [31:0]         o_perf_stall
`endif
);

  sched_state_t           state;
  logic [TILE_W-1:0]      num_tiles;
  logic [RUN_CNT_W-1:0]   run_cnt;

  logic [1:0]             grp_inc;
  logic                   collision;
  logic [TILE_W-1:0]      tile_idx_inc;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    grp_inc      = {1'b0, bus.i_enc_left_ready} + {1'b0, bus.i_enc_right_ready};
    collision    = (bus.i_enc_left_ready  && bus.i_pe_left_busy) ||
                   (bus.i_enc_right_ready && bus.i_pe_right_busy);
    tile_idx_inc = bus.o_tile_idx + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      num_tiles       <= '0;
      run_cnt         <= '0;
      bus.o_tile_req  <= 1'b0;
      bus.o_enc_start <= 1'b0;
      bus.o_enc_wlen  <= '0;
      bus.o_left_issue  <= 1'b0;
      bus.o_right_issue <= 1'b0;
      bus.o_tile_idx  <= '0;
      bus.o_group_cnt <= '0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_err       <= 1'b0;
    end else begin
      // Single-cycle pulses fall back low unless a state below raises them.
      bus.o_enc_start   <= 1'b0;
      bus.o_left_issue  <= 1'b0;
      bus.o_right_issue <= 1'b0;
      bus.o_done        <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.i_go) begin
            num_tiles      <= bus.i_num_tiles;
            bus.o_tile_idx <= '0;
            bus.o_err      <= 1'b0;
            bus.o_busy     <= 1'b1;
            if (bus.i_num_tiles == '0) begin
              state <= DONE;
            end else begin
              state          <= REQ;
              bus.o_tile_req <= 1'b1;
            end
          end
        end

        REQ: begin
          if (bus.i_tile_valid) begin
            bus.o_tile_req <= 1'b0;
            if (bus.i_tile_wlen == '0) begin
              // Empty tile: skip the encoder entirely.
              state <= NEXT;
            end else begin
              state           <= START;
              bus.o_enc_start <= 1'b1;
              bus.o_enc_wlen  <= bus.i_tile_wlen;
              bus.o_group_cnt <= '0;
            end
          end
        end

        START: begin
          state   <= RUN;
          run_cnt <= '0;
        end

        RUN: begin
          // Ready pulses are forwarded one cycle later, including in the finish cycle.
          bus.o_left_issue  <= bus.i_enc_left_ready;
          bus.o_right_issue <= bus.i_enc_right_ready;
          bus.o_group_cnt   <= bus.o_group_cnt + W_LEN_W'(grp_inc);
          if (collision) bus.o_err <= 1'b1;

          if (bus.i_enc_finish) begin
            state <= DRAIN;
          end else if (run_cnt == RUN_CNT_W'(TIMEOUT - 1)) begin
            // This was the TIMEOUT-th RUN cycle without finish.
            bus.o_err <= 1'b1;
            state     <= DONE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end

        DRAIN: begin
          if (!bus.i_pe_left_busy && !bus.i_pe_right_busy) state <= NEXT;
        end

        NEXT: begin
          bus.o_tile_idx <= tile_idx_inc;
          if (tile_idx_inc == num_tiles) begin
            state <= DONE;
          end else begin
            state          <= REQ;
            bus.o_tile_req <= 1'b1;
          end
        end

        DONE: begin
          // o_done lands in the first IDLE cycle; o_busy drops at the same edge.
          bus.o_done <= 1'b1;
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef VP_SCHED_PERF_EN
  logic go_accept;
  logic stall_cyc;

  always_comb begin
    go_accept = (state == IDLE) && bus.i_go;
    stall_cyc = (state == REQ) || (state == DRAIN);
  end

  vp_sched_perf_cnt u_perf_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (go_accept),
    .inc_a (bus.o_busy),
    .inc_b (stall_cyc),
    .cnt_a (o_perf_busy),
    .cnt_b (o_perf_stall)
  );
`endif

endmodule

// File: tb/tb_vp_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vp_tile_scheduler: directed bench for vp_tile_scheduler.
// Inputs change 1 time unit after each rising edge; outputs are compared at the
// same point, i.e. they show the value registered at the preceding edge.
// -----------------------------------------------------------------------------
module tb_vp_tile_scheduler;
  import vp_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Event tallies sampled mid-cycle on the falling edge.
  int   n_start, n_left, n_right, n_done, n_req;

  vp_tile_scheduler_if bus ();

`ifdef VP_SCHED_PERF_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_stall;
`endif

  vp_tile_scheduler dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
`ifdef VP_SCHED_PERF_EN
    ,
    .o_perf_busy  (perf_busy),
    .o_perf_stall (perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.o_enc_start   === 1'b1) n_start++;
    if (bus.o_left_issue  === 1'b1) n_left++;
    if (bus.o_right_issue === 1'b1) n_right++;
    if (bus.o_done        === 1'b1) n_done++;
    if (bus.o_tile_req    === 1'b1) n_req++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Entered in a REQ cycle; runs one tile with 2 left + 2 right pulses and a
  // finish, PEs idle, and returns two edges after DRAIN (next REQ or DONE).
  task automatic run_tile(input int idx, input logic [W_LEN_W-1:0] wlen);
    check($sformatf("t%0d_req", idx), 32'(bus.o_tile_req), 32'd1);
    check($sformatf("t%0d_idx", idx), 32'(bus.o_tile_idx), 32'(idx));
    bus.i_tile_valid = 1'b1;
    bus.i_tile_wlen  = wlen;
    tick();
    bus.i_tile_valid = 1'b0;
    check($sformatf("t%0d_start", idx), 32'(bus.o_enc_start), 32'd1);
    check($sformatf("t%0d_grp0", idx), 32'(bus.o_group_cnt), 32'd0);
    tick();
    bus.i_enc_left_ready  = 1'b1; tick();
    bus.i_enc_left_ready  = 1'b0;
    bus.i_enc_right_ready = 1'b1; tick();
    bus.i_enc_right_ready = 1'b0;
    bus.i_enc_left_ready  = 1'b1; tick();
    bus.i_enc_left_ready  = 1'b0;
    bus.i_enc_right_ready = 1'b1; tick();
    bus.i_enc_right_ready = 1'b0;
    bus.i_enc_finish      = 1'b1; tick();
    bus.i_enc_finish      = 1'b0;
    check($sformatf("t%0d_grp4", idx), 32'(bus.o_group_cnt), 32'd4);
    check($sformatf("t%0d_wlen_hold", idx), 32'(bus.o_enc_wlen), 32'(wlen));
    tick();
    tick();
  endtask

  int s_start, s_issue, s_done, s_req;

  initial begin
    checks = 0; errors = 0;
    n_start = 0; n_left = 0; n_right = 0; n_done = 0; n_req = 0;
    rst_n = 1'b0;
    bus.i_go = 1'b0;
    bus.i_num_tiles = '0;
    bus.i_tile_valid = 1'b0;
    bus.i_tile_wlen = '0;
    bus.i_enc_left_ready = 1'b0;
    bus.i_enc_right_ready = 1'b0;
    bus.i_enc_finish = 1'b0;
    bus.i_pe_left_busy = 1'b0;
    bus.i_pe_right_busy = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_req",  32'(bus.o_tile_req), 32'd0);
    check("rst_idx",  32'(bus.o_tile_idx), 32'd0);
    check("rst_grp",  32'(bus.o_group_cnt), 32'd0);
    check("rst_err",  32'(bus.o_err), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);

    // 1: three tiles of wlen 10, four pulses each
    s_start = n_start; s_issue = n_left + n_right; s_done = n_done;
    bus.i_go = 1'b1; bus.i_num_tiles = 8'd3;
    tick();
    bus.i_go = 1'b0;
    check("t1_busy", 32'(bus.o_busy), 32'd1);
    run_tile(0, 10'd10);
    run_tile(1, 10'd10);
    run_tile(2, 10'd10);
    check("t1_done_early", 32'(bus.o_done), 32'd0);
    tick();
    check("t1_done", 32'(bus.o_done), 32'd1);
    check("t1_busy_end", 32'(bus.o_busy), 32'd0);
    tick();
    check("t1_done_once", 32'(bus.o_done), 32'd0);
    check("t1_starts", 32'(n_start - s_start), 32'd3);
    check("t1_issues", 32'(n_left + n_right - s_issue), 32'd12);
    check("t1_done_cnt", 32'(n_done - s_done), 32'd1);
    check("t1_err", 32'(bus.o_err), 32'd0);
    check("t1_idx_final", 32'(bus.o_tile_idx), 32'd3);

    // 2: empty layer
    s_start = n_start; s_req = n_req;
    bus.i_go = 1'b1; bus.i_num_tiles = 8'd0;
    tick();
    bus.i_go = 1'b0;
    check("t2_done_c1", 32'(bus.o_done), 32'd0);
    check("t2_req_c1",  32'(bus.o_tile_req), 32'd0);
    tick();
    check("t2_done_c2", 32'(bus.o_done), 32'd1);
    tick();
    check("t2_done_c3", 32'(bus.o_done), 32'd0);
    check("t2_no_req",   32'(n_req - s_req), 32'd0);
    check("t2_no_start", 32'(n_start - s_start), 32'd0);

    // 3: first tile empty, second normal
    s_start = n_start; s_done = n_done;
    bus.i_go = 1'b1; bus.i_num_tiles = 8'd2;
    tick();
    bus.i_go = 1'b0;
    bus.i_tile_valid = 1'b1; bus.i_tile_wlen = 10'd0;
    tick();
    bus.i_tile_valid = 1'b0;
    check("t3_no_start", 32'(bus.o_enc_start), 32'd0);
    check("t3_req_drop", 32'(bus.o_tile_req), 32'd0);
    tick();
    run_tile(1, 10'd5);
    tick();
    check("t3_done", 32'(bus.o_done), 32'd1);
    tick();
    check("t3_starts", 32'(n_start - s_start), 32'd1);
    check("t3_done_cnt", 32'(n_done - s_done), 32'd1);

    // 4: both readies with finish, then a held DRAIN
    bus.i_go = 1'b1; bus.i_num_tiles = 8'd1;
    tick();
    bus.i_go = 1'b0;
    bus.i_tile_valid = 1'b1; bus.i_tile_wlen = 10'd7;
    tick();
    bus.i_tile_valid = 1'b0;
    tick();
    bus.i_enc_left_ready = 1'b1; bus.i_enc_right_ready = 1'b1; bus.i_enc_finish = 1'b1;
    tick();
    bus.i_enc_left_ready = 1'b0; bus.i_enc_right_ready = 1'b0; bus.i_enc_finish = 1'b0;
    bus.i_pe_left_busy = 1'b1;
    check("t4_left",  32'(bus.o_left_issue), 32'd1);
    check("t4_right", 32'(bus.o_right_issue), 32'd1);
    check("t4_grp",   32'(bus.o_group_cnt), 32'd2);
    tick();
    check("t4_left_pulse", 32'(bus.o_left_issue), 32'd0);
    tick();
    tick();
    check("t4_drain_hold", 32'(bus.o_done), 32'd0);
    check("t4_drain_busy", 32'(bus.o_busy), 32'd1);
    bus.i_pe_left_busy = 1'b0;
    tick();
    tick();
    check("t4_done_early", 32'(bus.o_done), 32'd0);
    tick();
    check("t4_done", 32'(bus.o_done), 32'd1);
    check("t4_err",  32'(bus.o_err), 32'd0);
    tick();

    // 5: encoder never finishes
    bus.i_go = 1'b1; bus.i_num_tiles = 8'd1;
    tick();
    bus.i_go = 1'b0;
    bus.i_tile_valid = 1'b1; bus.i_tile_wlen = 10'd3;
    tick();
    bus.i_tile_valid = 1'b0;
    tick();
    // now in RUN cycle 1; advance to RUN cycle 255
    for (int i = 0; i < 254; i++) tick();
    check("t5_err_254", 32'(bus.o_err), 32'd0);
    check("t5_busy_254", 32'(bus.o_busy), 32'd1);
    tick();
    check("t5_err_255", 32'(bus.o_err), 32'd1);
    check("t5_done_early", 32'(bus.o_done), 32'd0);
    tick();
    check("t5_done", 32'(bus.o_done), 32'd1);
    check("t5_busy_end", 32'(bus.o_busy), 32'd0);
    check("t5_err_sticky", 32'(bus.o_err), 32'd1);
    tick();
    bus.i_go = 1'b1; bus.i_num_tiles = 8'd0;
    tick();
    bus.i_go = 1'b0;
    check("t5_err_clr", 32'(bus.o_err), 32'd0);
    tick();
    tick();

    // 7: issue into a busy lane
    bus.i_go = 1'b1; bus.i_num_tiles = 8'd1;
    tick();
    bus.i_go = 1'b0;
    bus.i_tile_valid = 1'b1; bus.i_tile_wlen = 10'd4;
    tick();
    bus.i_tile_valid = 1'b0;
    tick();
    bus.i_enc_right_ready = 1'b1; bus.i_pe_right_busy = 1'b1;
    tick();
    bus.i_enc_right_ready = 1'b0; bus.i_pe_right_busy = 1'b0;
    check("t7_issue", 32'(bus.o_right_issue), 32'd1);
    check("t7_err",   32'(bus.o_err), 32'd1);
    bus.i_enc_finish = 1'b1;
    tick();
    bus.i_enc_finish = 1'b0;
    tick(); tick(); tick();
    check("t7_done", 32'(bus.o_done), 32'd1);
    check("t7_err_hold", 32'(bus.o_err), 32'd1);
    tick();

    // 6: i_go ignored while running, then reset mid-RUN
    bus.i_go = 1'b1; bus.i_num_tiles = 8'd2;
    tick();
    bus.i_go = 1'b0;
    bus.i_tile_valid = 1'b1; bus.i_tile_wlen = 10'd9;
    tick();
    bus.i_tile_valid = 1'b0;
    tick();
    bus.i_go = 1'b1; bus.i_num_tiles = 8'd1; bus.i_enc_left_ready = 1'b1;
    tick();
    bus.i_go = 1'b0; bus.i_enc_left_ready = 1'b0;
    check("t6_run_issue", 32'(bus.o_left_issue), 32'd1);
    check("t6_run_busy",  32'(bus.o_busy), 32'd1);
    bus.i_enc_finish = 1'b1;
    tick();
    bus.i_enc_finish = 1'b0;
    tick(); tick();
    check("t6_go_ignored_req", 32'(bus.o_tile_req), 32'd1);
    check("t6_go_ignored_idx", 32'(bus.o_tile_idx), 32'd1);
    bus.i_tile_valid = 1'b1; bus.i_tile_wlen = 10'd9;
    tick();
    bus.i_tile_valid = 1'b0;
    tick();
    bus.i_enc_left_ready = 1'b1;
    tick();
    bus.i_enc_left_ready = 1'b0;
    s_done = n_done;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_busy",  32'(bus.o_busy), 32'd0);
    check("t6_rst_idx",   32'(bus.o_tile_idx), 32'd0);
    check("t6_rst_grp",   32'(bus.o_group_cnt), 32'd0);
    check("t6_rst_wlen",  32'(bus.o_enc_wlen), 32'd0);
    check("t6_rst_issue", 32'(bus.o_left_issue), 32'd0);
    tick(); tick();
    check("t6_no_done", 32'(n_done - s_done), 32'd0);
    bus.i_go = 1'b1; bus.i_num_tiles = 8'd0;
    tick();
    bus.i_go = 1'b0;
    tick();
    check("t6_idle_go", 32'(bus.o_done), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
